// File: rtl/cp0_timer_ext.sv
// Coprocessor 0: SR/Cause/EPC exception and interrupt control, Count/Compare timer, BadVAddr, PRId.
// req and epc_out are combinational; register updates land at the next clk edge; no backpressure.
module cp0_timer_ext #(
    parameter int          HW_INT_W   = 6,
    parameter int          IM_LSB     = 10,
    parameter int          TIMER_LINE = HW_INT_W - 1,
    parameter int          CNT_DIV    = 1,
    parameter logic [31:0] PRID       = 32'h0000_7C07
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [4:0]          cp0_addr,
    input  logic [31:0]         cp0_wdata,
    output logic [31:0]         cp0_rdata,
    input  logic [31:0]         vpc,
    input  logic                bd_in,
    input  logic [4:0]          exc_code_in,
    input  logic [31:0]         bad_vaddr_in,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic                exl_clr,
    output logic [31:0]         epc_out,
    output logic                req
);

    localparam int             PW        = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CNT_DIV - 1);

    logic [HW_INT_W-1:0] im;
    logic [HW_INT_W-1:0] ip;
    logic                exl;
    logic                ie;
    logic                bd;
    logic                ti;
    logic [4:0]          exc_code;
    logic [31:0]         epc;
    logic [31:0]         bad_vaddr;
    logic [31:0]         count;
    logic [31:0]         compare;
    logic [PW-1:0]       presc;

    logic [HW_INT_W-1:0] pend;
    logic                int_req;
    logic                exc_req;
    logic [31:0]         new_epc;
    logic                wr_en;
    logic                wr_cnt;
    logic                wr_cmp;
    logic                wr_sr;
    logic                wr_epc;
    logic                tick;
    logic [31:0]         count_inc;
    logic [31:0]         sr_val;
    logic [31:0]         cause_val;
    logic                unused_wdata;

    always_comb begin
        pend             = hw_int;
        pend[TIMER_LINE] = hw_int[TIMER_LINE] | ti;
    end

    assign int_req   = !exl && ie && (|(pend & im));
    assign exc_req   = !exl && (exc_code_in != 5'd0);
    assign req       = int_req || exc_req;
    assign new_epc   = bd_in ? (vpc - 32'd4) : vpc;
    assign epc_out   = req ? new_epc : epc;

    // A taken exception/interrupt swallows every mtc0 in the same cycle.
    assign wr_en     = we && !req;
    assign wr_cnt    = wr_en && (cp0_addr == 5'd9);
    assign wr_cmp    = wr_en && (cp0_addr == 5'd11);
    assign wr_sr     = wr_en && (cp0_addr == 5'd12);
    assign wr_epc    = wr_en && (cp0_addr == 5'd14);

    assign tick      = (presc == PRESC_MAX);
    assign count_inc = count + 32'd1;

    assign unused_wdata = ^cp0_wdata;

    always_comb begin
        sr_val                       = '0;
        sr_val[IM_LSB +: HW_INT_W]   = im;
        sr_val[1]                    = exl;
        sr_val[0]                    = ie;
        cause_val                    = '0;
        cause_val[31]                = bd;
        cause_val[30]                = ti;
        cause_val[IM_LSB +: HW_INT_W] = ip;
        cause_val[6:2]               = exc_code;
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            5'd8:    cp0_rdata = bad_vaddr;
            5'd9:    cp0_rdata = count;
            5'd11:   cp0_rdata = compare;
            5'd12:   cp0_rdata = sr_val;
            5'd13:   cp0_rdata = cause_val;
            5'd14:   cp0_rdata = epc;
            5'd15:   cp0_rdata = PRID;
            default: cp0_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im        <= '0;
            ip        <= '0;
            exl       <= 1'b0;
            ie        <= 1'b0;
            bd        <= 1'b0;
            ti        <= 1'b0;
            exc_code  <= '0;
            epc       <= '0;
            bad_vaddr <= '0;
            count     <= '0;
            compare   <= '0;
            presc     <= '0;
        end else begin
            ip <= pend;

            if (wr_sr) begin
                im  <= cp0_wdata[IM_LSB +: HW_INT_W];
                ie  <= cp0_wdata[0];
            end
            // Exception entry dominates eret, which dominates an SR write.
            if (req) begin
                exl <= 1'b1;
            end else if (exl_clr) begin
                exl <= 1'b0;
            end else if (wr_sr) begin
                exl <= cp0_wdata[1];
            end

            if (req) begin
                bd       <= bd_in;
                epc      <= new_epc;
                exc_code <= int_req ? 5'd0 : exc_code_in;
                if (!int_req && (exc_code_in == 5'd4 || exc_code_in == 5'd5)) begin
                    bad_vaddr <= bad_vaddr_in;
                end
            end else if (wr_epc) begin
                epc <= cp0_wdata;
            end

            if (wr_cnt) begin
                count <= cp0_wdata;
                presc <= '0;
            end else begin
                if (tick) begin
                    count <= count_inc;
                end
                presc <= tick ? '0 : presc + 1'b1;
            end

            if (wr_cmp) begin
                compare <= cp0_wdata;
            end

            // Compare write clears TI and wins over any set condition.
            if (wr_cmp) begin
                ti <= 1'b0;
            end else if ((wr_cnt && cp0_wdata == compare) ||
                         (!wr_cnt && tick && count_inc == compare)) begin
                ti <= 1'b1;
            end
        end
    end

endmodule
